// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one unified I/D memory port between fetch and data requesters
// Optional wait-cycle counters: define ARB_PERF_CNT_EN to add perf_if_wait / perf_d_wait.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_if_wait,
    output logic [31:0]       perf_d_wait
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] streak;
    logic       drop;
    logic       grant_d;
    logic       grant_i;
    logic       drop_now;

    // Data wins ties unless it has already starved a waiting fetch for STREAK_MAX grants.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state == IDLE) begin
            if (d_req && !(if_req && (streak == STREAK_MAX))) begin
                grant_d = 1'b1;
            end else if (if_req) begin
                grant_i = 1'b1;
            end
        end
    end

    assign drop_now = drop || if_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt = BUSY_D;
                end else if (grant_i) begin
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I: begin
                if (mem_ready) begin
                    state_nxt = drop_now ? IDLE : RESP_I;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    state_nxt = RESP_D;
                end
            end
            RESP_I:  state_nxt = IDLE;
            RESP_D:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        if_ack = (state == RESP_I);
        d_ack  = (state == RESP_D);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            streak    <= '0;
            drop      <= 1'b0;
        end else begin
            if (grant_d) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                if (if_req) begin
                    streak <= (streak == STREAK_MAX) ? streak : streak + 4'd1;
                end else begin
                    streak <= '0;
                end
            end else if (grant_i) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                streak    <= '0;
            end

            // A flushed fetch still waits for the memory, then is discarded silently.
            if (state == BUSY_I) begin
                if (if_flush) begin
                    drop <= 1'b1;
                end
                if (mem_ready) begin
                    mem_req <= 1'b0;
                    drop    <= 1'b0;
                    if (!drop_now) begin
                        if_rdata <= mem_rdata;
                    end
                end
            end

            if ((state == BUSY_D) && mem_ready) begin
                mem_req <= 1'b0;
                if (!mem_we) begin
                    d_rdata <= mem_rdata;
                end
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_if_wait <= '0;
            perf_d_wait  <= '0;
        end else begin
            if (if_req && (state != RESP_I)) begin
                perf_if_wait <= perf_if_wait + 32'd1;
            end
            if (d_req && (state != RESP_D)) begin
                perf_d_wait <= perf_d_wait + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_ack;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_ack;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          drop;
    } acc_t;

    typedef struct packed {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dreq_t;

    typedef struct packed {
        bit          is_d;
        bit          we;
        bit          pre;
        bit          flush;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    acc_t        exp_q[$];
    acc_t        ack_q[$];
    acc_t        cur;
    logic [31:0] i_pend[$];
    dreq_t       d_pend[$];
    logic [31:0] memarr[logic [31:0]];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 0;
    int bcnt = 0;
    int busy_len = 0;
    int idle_len = 0;
    int last_gap = 0;
    int last_rise_cyc = 0;
    int last_if_ack_cyc = 0;
    int n_if_ack = 0;
    int n_d_ack = 0;
    bit prev_mreq = 1'b0;
    bit spurious = 1'b0;
    bit flush_pending = 1'b0;
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_d_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (memarr.exists(a)) return memarr[a];
        return a ^ 32'h1234_5678;
    endfunction

    function automatic acc_t mk(input bit is_d, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata, input bit drop);
        acc_t a;
        a.is_d = is_d; a.we = we; a.addr = addr; a.wdata = wdata; a.rdata = rdata; a.drop = drop;
        return a;
    endfunction

    task automatic monitor();
        acc_t e;
        bit   ok;
        if (prev_mreq && !mem_req) begin
            chk("busy_len", busy_len, lat + 1);
            if (!cur.drop) ack_q.push_back(cur);
        end
        if (mem_req && !prev_mreq) begin
            last_gap = idle_len;
            last_rise_cyc = cyc;
            ok = (exp_q.size() > 0);
            chk("grant_expected", 32'(ok), 1);
            if (ok) begin
                cur = exp_q.pop_front();
                chk("grant_addr", mem_addr, cur.addr);
                chk("grant_we", 32'(mem_we), 32'(cur.we));
                chk("grant_wdata", mem_wdata, cur.wdata);
            end
            busy_len = 0;
        end else if (mem_req) begin
            chk("hold", 32'(mem_addr === cur.addr && mem_we === cur.we && mem_wdata === cur.wdata), 1);
        end
        if (mem_req) begin
            busy_len++;
            idle_len = 0;
        end else begin
            idle_len++;
        end
        if (if_ack || d_ack) chk("ack_exclusive", 32'(if_ack && d_ack), 0);
        if (if_ack) begin
            n_if_ack++;
            last_if_ack_cyc = cyc;
            ok = (ack_q.size() > 0) && !ack_q[0].is_d;
            chk("if_ack_expected", 32'(ok), 1);
            if (ok) begin
                e = ack_q.pop_front();
                exp_if_rdata = e.rdata;
                chk("if_rdata", if_rdata, exp_if_rdata);
            end
        end
        if (d_ack) begin
            n_d_ack++;
            ok = (ack_q.size() > 0) && ack_q[0].is_d;
            chk("d_ack_expected", 32'(ok), 1);
            if (ok) begin
                e = ack_q.pop_front();
                if (!e.we) exp_d_rdata = e.rdata;
                chk("d_rdata", d_rdata, exp_d_rdata);
            end
        end
        prev_mreq = mem_req;
    endtask

    task automatic mem_model();
        if (mem_req) begin
            if (bcnt >= lat) begin
                mem_ready = 1'b1;
                mem_rdata = mem_val(mem_addr);
                if (mem_we) memarr[mem_addr] = mem_wdata;
                bcnt = 0;
            end else begin
                mem_ready = 1'b0;
                bcnt++;
            end
        end else begin
            bcnt = 0;
            mem_ready = spurious;
            if (spurious) mem_rdata = 32'hBAD0_BAD0;
        end
    endtask

    task automatic drive_reqs();
        if_req  = (i_pend.size() > 0);
        if_addr = if_req ? i_pend[0] : '0;
        d_req   = (d_pend.size() > 0);
        d_we    = d_req ? d_pend[0].we : 1'b0;
        d_addr  = d_req ? d_pend[0].addr : '0;
        d_wdata = d_req ? d_pend[0].wdata : '0;
    endtask

    task automatic agents();
        if (if_ack && i_pend.size() > 0) void'(i_pend.pop_front());
        if (d_ack && d_pend.size() > 0) void'(d_pend.pop_front());
        if_flush = 1'b0;
        if (flush_pending && mem_req) begin
            if_flush = 1'b1;
            flush_pending = 1'b0;
            if (!cur.is_d && i_pend.size() > 0) void'(i_pend.pop_front());
        end
        drive_reqs();
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
        mem_model();
        agents();
    endtask

    task automatic run_done(input string name, input int bound);
        int n;
        n = 0;
        while ((exp_q.size() + ack_q.size() + i_pend.size() + d_pend.size()) != 0
               || mem_req || if_ack || d_ack) begin
            tick();
            n++;
            if (n >= bound) begin
                checks++;
                errors++;
                $display("FAIL timeout %s: still busy after %0d cycles, limit %0d", name, n, bound);
                exp_q.delete(); ack_q.delete(); i_pend.delete(); d_pend.delete();
                drive_reqs();
                break;
            end
        end
        chk({name, "_if_rdata_hold"}, if_rdata, exp_if_rdata);
        chk({name, "_d_rdata_hold"}, d_rdata, exp_d_rdata);
    endtask

    task automatic bench_clear();
        exp_q.delete(); ack_q.delete(); i_pend.delete(); d_pend.delete();
        drive_reqs();
        if_flush = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        bcnt = 0; busy_len = 0; idle_len = 0;
        prev_mreq = 1'b0; spurious = 1'b0; flush_pending = 1'b0;
        exp_if_rdata = '0; exp_d_rdata = '0;
    endtask

    vec_t vecs[8];

    initial begin
        int t0, ni, nd;
        vecs[0] = '{is_d:1'b0, we:1'b0, pre:1'b1, flush:1'b0, addr:32'h20,        wdata:32'h0,         rdata:32'h1111_0001, lat:1};
        vecs[1] = '{is_d:1'b1, we:1'b0, pre:1'b1, flush:1'b0, addr:32'h1000,      wdata:32'h0,         rdata:32'h2222_0002, lat:0};
        vecs[2] = '{is_d:1'b1, we:1'b1, pre:1'b0, flush:1'b0, addr:32'h200,       wdata:32'hDEAD_BEEF, rdata:32'h0,         lat:3};
        vecs[3] = '{is_d:1'b1, we:1'b0, pre:1'b0, flush:1'b0, addr:32'h200,       wdata:32'h0,         rdata:32'hDEAD_BEEF, lat:2};
        vecs[4] = '{is_d:1'b0, we:1'b0, pre:1'b1, flush:1'b1, addr:32'h30,        wdata:32'h0,         rdata:32'hAAAA_AAAA, lat:2};
        vecs[5] = '{is_d:1'b1, we:1'b0, pre:1'b1, flush:1'b1, addr:32'h1004,      wdata:32'h0,         rdata:32'h3333_0003, lat:2};
        vecs[6] = '{is_d:1'b0, we:1'b0, pre:1'b1, flush:1'b0, addr:32'hFFFF_FFFC, wdata:32'h0,         rdata:32'h4444_0004, lat:4};
        vecs[7] = '{is_d:1'b1, we:1'b1, pre:1'b0, flush:1'b0, addr:32'h0,         wdata:32'h0000_0001, rdata:32'h0,         lat:1};

        rst = 1'b1;
        bench_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_ack", 32'(if_ack), 0);
        chk("rst_d_ack", 32'(d_ack), 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        rst = 1'b0;
        tick();

        // fetch only: ack on the third cycle counting the request cycle
        memarr[32'h10] = 32'h0000_0013;
        lat = 0;
        ni = n_if_ack;
        exp_q.push_back(mk(1'b0, 1'b0, 32'h10, 32'h0, 32'h0000_0013, 1'b0));
        i_pend.push_back(32'h10);
        drive_reqs();
        t0 = cyc;
        run_done("fetch", 50);
        chk("fetch_grant_cycle", last_rise_cyc - t0, 1);
        chk("fetch_ack_cycle", last_if_ack_cyc - t0, 2);
        chk("fetch_ack_count", n_if_ack - ni, 1);

        for (int i = 0; i < 8; i++) begin
            lat = vecs[i].lat;
            if (vecs[i].pre) memarr[vecs[i].addr] = vecs[i].rdata;
            ni = n_if_ack;
            nd = n_d_ack;
            exp_q.push_back(mk(vecs[i].is_d, vecs[i].we, vecs[i].addr, vecs[i].is_d ? vecs[i].wdata : 32'h0,
                               vecs[i].rdata, vecs[i].flush && !vecs[i].is_d));
            if (vecs[i].is_d) d_pend.push_back('{we:vecs[i].we, addr:vecs[i].addr, wdata:vecs[i].wdata});
            else i_pend.push_back(vecs[i].addr);
            flush_pending = vecs[i].flush;
            drive_reqs();
            run_done($sformatf("vec%0d", i), 60);
            chk($sformatf("vec%0d_if_acks", i), n_if_ack - ni, (!vecs[i].is_d && !vecs[i].flush) ? 1 : 0);
            chk($sformatf("vec%0d_d_acks", i), n_d_ack - nd, vecs[i].is_d ? 1 : 0);
        end

        // simultaneous requests: data first, no re-grant during RESP
        lat = 0;
        memarr[32'h100] = 32'h5555_0100;
        memarr[32'h104] = 32'h6666_0104;
        ni = n_if_ack;
        nd = n_d_ack;
        exp_q.push_back(mk(1'b1, 1'b0, 32'h100, 32'h0, 32'h5555_0100, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 32'h104, 32'h0, 32'h6666_0104, 1'b0));
        d_pend.push_back('{we:1'b0, addr:32'h100, wdata:32'h0});
        i_pend.push_back(32'h104);
        drive_reqs();
        run_done("simul", 50);
        chk("simul_gap", last_gap, 2);
        chk("simul_if_acks", n_if_ack - ni, 1);
        chk("simul_d_acks", n_d_ack - nd, 1);

        // starvation: four data grants, one fetch, then data resumes
        lat = 0;
        memarr[32'h40] = 32'h7070_0040;
        for (int k = 0; k < 6; k++) begin
            memarr[32'h300 + 4 * k] = 32'hA000_0000 + k;
            d_pend.push_back('{we:1'b0, addr:32'h300 + 4 * k, wdata:32'h0});
        end
        for (int k = 0; k < 4; k++)
            exp_q.push_back(mk(1'b1, 1'b0, 32'h300 + 4 * k, 32'h0, 32'hA000_0000 + k, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 32'h40, 32'h0, 32'h7070_0040, 1'b0));
        for (int k = 4; k < 6; k++)
            exp_q.push_back(mk(1'b1, 1'b0, 32'h300 + 4 * k, 32'h0, 32'hA000_0000 + k, 1'b0));
        i_pend.push_back(32'h40);
        ni = n_if_ack;
        nd = n_d_ack;
        drive_reqs();
        run_done("starve", 100);
        chk("starve_if_acks", n_if_ack - ni, 1);
        chk("starve_d_acks", n_d_ack - nd, 6);

        // flush with a data request waiting: arbiter must be IDLE right after mem_ready
        lat = 2;
        memarr[32'h50] = 32'hAAAA_AAAA;
        memarr[32'h60] = 32'h6060_6060;
        exp_q.push_back(mk(1'b0, 1'b0, 32'h50, 32'h0, 32'hAAAA_AAAA, 1'b1));
        i_pend.push_back(32'h50);
        flush_pending = 1'b1;
        drive_reqs();
        tick();
        exp_q.push_back(mk(1'b1, 1'b0, 32'h60, 32'h0, 32'h6060_6060, 1'b0));
        d_pend.push_back('{we:1'b0, addr:32'h60, wdata:32'h0});
        drive_reqs();
        run_done("flush", 60);
        chk("flush_gap", last_gap, 1);
        memarr[32'h54] = 32'h5454_5454;
        ni = n_if_ack;
        exp_q.push_back(mk(1'b0, 1'b0, 32'h54, 32'h0, 32'h5454_5454, 1'b0));
        i_pend.push_back(32'h54);
        drive_reqs();
        run_done("post_flush", 50);
        chk("post_flush_if_acks", n_if_ack - ni, 1);

        // mem_ready outside BUSY is ignored
        spurious = 1'b1;
        lat = 2;
        ni = n_if_ack;
        repeat (3) tick();
        memarr[32'h70] = 32'h7777_0007;
        exp_q.push_back(mk(1'b0, 1'b0, 32'h70, 32'h0, 32'h7777_0007, 1'b0));
        i_pend.push_back(32'h70);
        drive_reqs();
        run_done("spurious", 50);
        repeat (2) tick();
        chk("spurious_if_acks", n_if_ack - ni, 1);
        spurious = 1'b0;

        // asynchronous reset in the middle of a data access
        lat = 6;
        exp_q.push_back(mk(1'b1, 1'b0, 32'h400, 32'h0, 32'h0, 1'b0));
        d_pend.push_back('{we:1'b0, addr:32'h400, wdata:32'h0});
        drive_reqs();
        tick();
        tick();
        chk("pre_rst_busy", 32'(mem_req), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_mem_req", 32'(mem_req), 0);
        chk("async_rst_d_ack", 32'(d_ack), 0);
        chk("async_rst_if_ack", 32'(if_ack), 0);
        chk("async_rst_if_rdata", if_rdata, 0);
        bench_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_mem_req", 32'(mem_req), 0);
        lat = 1;
        memarr[32'h80] = 32'h8080_8080;
        ni = n_if_ack;
        exp_q.push_back(mk(1'b0, 1'b0, 32'h80, 32'h0, 32'h8080_8080, 1'b0));
        i_pend.push_back(32'h80);
        drive_reqs();
        run_done("post_rst", 50);
        chk("post_rst_if_acks", n_if_ack - ni, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
